// File: rtl/monolith_stream_pkg.sv
// Shared defaults, input FSM encoding and word/state typedefs for the
// Monolith stream sequencer.
package monolith_stream_pkg;

  localparam int DATA_W_DEF    = 31;
  localparam int PERM_SIZE_DEF = 16;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } in_state_e;

  typedef logic [DATA_W_DEF-1:0]               word_t;
  typedef logic [PERM_SIZE_DEF*DATA_W_DEF-1:0] perm_state_t;

  // Index width that stays legal (>=1 bit) for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/monolith_chunk_fifo.sv
// Result-chunk FIFO: one entry per hash result, simultaneous push/pop allowed
// even when full; a push that cannot be stored is reported on drop.
module monolith_chunk_fifo
  import monolith_stream_pkg::*;
#(
  parameter int WIDTH = 248,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  assign head_data = mem_q[rd_ptr_q];

  // NOTE: payload storage has no reset; emptiness is defined by count_q alone,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/monolith_stream_sequencer.sv
// Assembles AXIS words into permutation states, issues them to a non-stalling
// hash engine under a credit scheme, and streams result words back out.
module monolith_stream_sequencer
  import monolith_stream_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PERM_SIZE = PERM_SIZE_DEF,
  parameter int OUT_WORDS = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [DATA_W-1:0]             s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic [PERM_SIZE*DATA_W-1:0]   hash_state_in,
  output logic                          hash_in_valid,
  input  logic [PERM_SIZE*DATA_W-1:0]   hash_state_out,
  input  logic                          hash_out_valid,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          err_tlast,
  output logic                          err_overflow,
  output logic [$clog2(OUT_DEPTH+1)-1:0] credits
);

  localparam int IN_IDX_W  = idx_width(PERM_SIZE);
  localparam int OUT_IDX_W = idx_width(OUT_WORDS);
  localparam int CRED_W    = $clog2(OUT_DEPTH + 1);
  localparam int CHUNK_W   = OUT_WORDS * DATA_W;

  localparam logic [IN_IDX_W-1:0]  IN_LAST  = IN_IDX_W'(PERM_SIZE - 1);
  localparam logic [OUT_IDX_W-1:0] OUT_LAST = OUT_IDX_W'(OUT_WORDS - 1);
  localparam logic [CRED_W-1:0]    CRED_MAX = CRED_W'(OUT_DEPTH);

  in_state_e            state_q;
  logic [IN_IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0]    chunk_q [PERM_SIZE];
  logic                 err_tlast_q;
  logic [CRED_W-1:0]    credits_q, credits_d;
  logic [OUT_IDX_W-1:0] out_idx_q;
  logic                 overflow_q;

  logic               beat, issue, out_beat, pop_chunk;
  logic [CHUNK_W-1:0] fifo_head;
  logic               fifo_full, fifo_empty, fifo_drop;

  assign s_axis_tready = (state_q == ST_FILL);
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign issue         = (state_q == ST_HOLD) && (credits_q != '0);
  assign hash_in_valid = issue;
  assign err_tlast     = err_tlast_q;
  assign err_overflow  = overflow_q;
  assign credits       = credits_q;

  for (genvar g = 0; g < PERM_SIZE; g++) begin : g_pack
    assign hash_state_in[g*DATA_W +: DATA_W] = chunk_q[g];
  end

  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      err_tlast_q <= 1'b0;
      for (int w = 0; w < PERM_SIZE; w++) chunk_q[w] <= '0;
    end else begin
      err_tlast_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          if (beat) begin
            chunk_q[idx_q] <= s_axis_tdata;
            if (idx_q == IN_LAST) begin
              state_q     <= ST_HOLD;
              idx_q       <= '0;
              err_tlast_q <= !s_axis_tlast;
            end else if (s_axis_tlast) begin
              // Early tlast: the partial chunk is abandoned.
              idx_q       <= '0;
              err_tlast_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (issue) state_q <= ST_FILL;
        end
      endcase
    end
  end

  // NOTE: always_comb outputs get a default first so no path can infer a latch.
  always_comb begin
    credits_d = credits_q;
    if (issue && !pop_chunk)                         credits_d = credits_q - 1'b1;
    else if (!issue && pop_chunk && credits_q != CRED_MAX) credits_d = credits_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q  <= CRED_MAX;
      overflow_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      if (fifo_drop) overflow_q <= 1'b1;
    end
  end

  monolith_chunk_fifo #(
    .WIDTH (CHUNK_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (hash_out_valid),
    .push_data (hash_state_out[CHUNK_W-1:0]),
    .pop       (pop_chunk),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  // Words beyond OUT_WORDS are intentionally ignored in compression mode.
  logic unused_hash_bits;
  assign unused_hash_bits = ^hash_state_out ^ fifo_full;

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tlast  = m_axis_tvalid && (out_idx_q == OUT_LAST);
  assign out_beat      = m_axis_tvalid && m_axis_tready;
  assign pop_chunk     = out_beat && m_axis_tlast;

  always_comb begin
    m_axis_tdata = '0;
    for (int w = 0; w < OUT_WORDS; w++) begin
      if (out_idx_q == OUT_IDX_W'(w)) m_axis_tdata = fifo_head[w*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_idx_q <= '0;
    end else if (out_beat) begin
      out_idx_q <= m_axis_tlast ? '0 : out_idx_q + 1'b1;
    end
  end

endmodule

// File: doc/monolith_stream_sequencer.md
MONOLITH_STREAM_SEQUENCER -- requirements
Module: monolith_stream_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 31, width of one field element / AXIS word.
REQ-002 SHALL have parameter PERM_SIZE, default 16, number of words in one permutation state.
REQ-003 SHALL have parameter OUT_WORDS, default 16, range 1..PERM_SIZE, number of leading state words emitted per result (8 gives compression mode).
REQ-004 SHALL have parameter OUT_DEPTH, default 4, range >=1, result chunks the output buffer holds.
REQ-005 SHALL have ports clk (in, 1, sole clock) and reset (in, 1, asynchronous, active-high).
REQ-006 SHALL have ports s_axis_tvalid (in, 1), s_axis_tready (out, 1), s_axis_tdata (in, DATA_W) and s_axis_tlast (in, 1), forming the input word stream.
REQ-007 SHALL have ports hash_state_in (out, PERM_SIZE*DATA_W; word i at bits [i*DATA_W +: DATA_W]) and hash_in_valid (out, 1), driving the hash engine.
REQ-008 SHALL have ports hash_state_out (in, PERM_SIZE*DATA_W) and hash_out_valid (in, 1), carrying hash engine results.
REQ-009 SHALL have ports m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tdata (out, DATA_W) and m_axis_tlast (out, 1), forming the output word stream.
REQ-010 SHALL have ports err_tlast (out, 1, one-cycle pulse), err_overflow (out, 1, sticky) and credits (out, clog2(OUT_DEPTH+1), free result slots).

Function
REQ-011 Input FSM states SHALL be FILL (s_axis_tready=1, word index 0..PERM_SIZE-1) and HOLD (s_axis_tready=0, assembled chunk waiting for credit).
REQ-012 An accepted beat (tvalid&tready) at index i SHALL write word i and increment the index; the beat at index PERM_SIZE-1 SHALL move FILL->HOLD and reset the index to 0.
REQ-013 tlast on a beat with index<PERM_SIZE-1 SHALL discard the partial chunk, reset the index to 0, stay in FILL and pulse err_tlast the next cycle.
REQ-014 A missing tlast on the index PERM_SIZE-1 beat SHALL pulse err_tlast while the chunk is still completed normally.
REQ-015 In HOLD with credits>0, hash_in_valid SHALL be 1 for exactly one cycle, during which hash_state_in holds the chunk; the FSM SHALL then return to FILL, giving s_axis_tready=1 the next cycle.
REQ-016 hash_state_in SHALL be stable from HOLD entry until the issue cycle ends.
REQ-017 credits SHALL decrement on each issue and increment on each output handshake with m_axis_tlast=1; both events in the same cycle leave credits unchanged.
REQ-018 credits SHALL never exceed OUT_DEPTH nor fall below 0.
REQ-019 With credits=0 the FSM SHALL remain in HOLD, stalling input, which is the only backpressure path, since the hash pipeline cannot stall.
REQ-020 hash_out_valid SHALL push words 0..OUT_WORDS-1 of hash_state_out into the chunk FIFO.
REQ-021 A push into a full FIFO SHALL be dropped and SHALL set err_overflow, which only reset clears.
REQ-022 m_axis_tvalid SHALL be 1 whenever the FIFO is non-empty; m_axis_tdata SHALL be word out_idx of the head chunk; m_axis_tlast SHALL be 1 when out_idx=OUT_WORDS-1.
REQ-023 The tlast handshake SHALL pop the head chunk and reset out_idx to 0.
REQ-024 m_axis_tdata and m_axis_tlast SHALL hold steady while tvalid&!tready.
REQ-025 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-026 Latency: final input beat at cycle T -> hash_in_valid at T+1 (given credit); hash_out_valid at T+1+L (L = engine latency) -> m_axis_tvalid at T+2+L.
REQ-027 Issue order SHALL equal output order, since the engine is in-order and the FIFO is FIFO.

Reset
REQ-028 On reset assertion, all state SHALL clear asynchronously: FSM=FILL, index=0, out_idx=0, FIFO empty, credits=OUT_DEPTH, err_overflow=0.
REQ-029 During and after reset, outputs SHALL be s_axis_tready=1 (after release), hash_in_valid=0, m_axis_tvalid=0, m_axis_tlast=0 and err_tlast=0.
REQ-030 Reset asserted mid-chunk or mid-output SHALL discard partial input and buffered results; the hash engine shares the same reset.

Structure
REQ-031 Package monolith_stream_pkg SHALL hold the DATA_W/PERM_SIZE defaults, the input FSM state enum and the word/state typedefs.
REQ-032 The chunk FIFO SHALL be sub-module monolith_chunk_fifo, parameterised by width OUT_WORDS*DATA_W and depth OUT_DEPTH, with full/empty and simultaneous push/pop.

Verification (DATA_W=31, PERM_SIZE=16, OUT_WORDS=8, OUT_DEPTH=2, engine model L=10)
REQ-033 Send words 0..15 with tlast on word 15 and m_axis_tready=1 -> one hash_in_valid pulse with word i=i; 8 output beats equal to the model's words 0..7; tlast on beat 8; credits 2->1->2.
REQ-034 Send 3 chunks with m_axis_tready=0 -> 2 issues; third chunk stalls in HOLD with s_axis_tready=0 and credits=0; raising tready issues the third chunk 1 cycle after the first tlast handshake.
REQ-035 Send tlast on word 5 -> err_tlast pulse, no issue; the next 16-word chunk is processed normally.
REQ-036 Send 16 words without tlast -> err_tlast pulse and the chunk is still issued.
REQ-037 Random tready at 50% over 20 chunks -> output equals the model in order; m_axis_tdata stable while stalled; err_overflow=0.
REQ-038 Assert reset after word 9, then send a full chunk -> the first output equals the new chunk's hash; credits=2 after release.
